// File: rtl/cr_huf_comp_lut_pp_ctrl_if.sv
// Handshake bundle between the LUT ping-pong controller and its clients
// (hw/st table builders and the symbol assembler).
//   master : client side; drives requests, done pulses, SA start/return.
//   slave  : controller side; drives grant, SA presentation, full/err status.
// Parameter SEQ_W: sequence-id width.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

interface cr_huf_comp_lut_pp_ctrl_if #(
  parameter int unsigned SEQ_W = `CREOLE_HC_SEQID_WIDTH
);
  logic             bld_req;
  logic [SEQ_W-1:0] bld_seq_id;
  logic             bld_gnt;
  logic             bld_bank;
  logic             hw_done;
  logic             st_done;
  logic             sa_vld;
  logic             sa_bank;
  logic [SEQ_W-1:0] sa_seq_id;
  logic             sa_start;
  logic             sa_ret_ack;
  logic [SEQ_W-1:0] sa_ack_seq_id;
  logic [1:0]       lut_full;
  logic             seq_err;

  modport master (
    output bld_req, bld_seq_id, hw_done, st_done, sa_start, sa_ret_ack, sa_ack_seq_id,
    input  bld_gnt, bld_bank, sa_vld, sa_bank, sa_seq_id, lut_full, seq_err
  );

  modport slave (
    input  bld_req, bld_seq_id, hw_done, st_done, sa_start, sa_ret_ack, sa_ack_seq_id,
    output bld_gnt, bld_bank, sa_vld, sa_bank, sa_seq_id, lut_full, seq_err
  );
endinterface

// File: rtl/cr_huf_comp_lut_pp_ctrl.sv
// Ping-pong bank scheduler for the two long-symbol Huffman LUTs.
// Allocates bank 0/1 to each table build, tracks hw/st fill completion,
// presents completed banks to the symbol assembler in allocation order and
// frees a bank on the SA return acknowledge.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of cr_huf_comp_lut_pp_ctrl_if (builder/SA handshakes,
//           lut_full per-bank busy, seq_err)
// Optional feature: define CR_HUF_COMP_LUT_PP_SEQCHK_EN to compare the SA
// returned sequence id with the stored one and pulse seq_err on mismatch;
// otherwise seq_err is tied low.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module cr_huf_comp_lut_pp_ctrl #(
  parameter int unsigned SEQ_W = `CREOLE_HC_SEQID_WIDTH
) (
  input logic                      clk,
  input logic                      rst_n,
  cr_huf_comp_lut_pp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StRdy  = 2'd2,
    StRead = 2'd3
  } bank_st_e;

  bank_st_e         state_q  [2];
  bank_st_e         state_d  [2];
  logic [SEQ_W-1:0] seq_id_q [2];
  logic [SEQ_W-1:0] seq_id_d [2];
  logic [1:0]       hw_seen_q, hw_seen_d;
  logic [1:0]       st_seen_q, st_seen_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             bld_gnt_q, bld_gnt_d;
  logic             bld_bank_q, bld_bank_d;
  logic [1:0]       lut_full_q, lut_full_d;

  logic any_fill, fill_idx, gnt_ok, start_ok, ret_ok, hw_nxt, st_nxt;

  always_comb begin
    // Only one bank may be in FILL, so fill_idx is unambiguous when any_fill.
    any_fill = (state_q[0] == StFill) || (state_q[1] == StFill);
    fill_idx = (state_q[1] == StFill);
    // Grant decision uses pre-edge state: a bank released this cycle is not
    // re-granted until the next one.
    gnt_ok   = bus.bld_req && !any_fill && (state_q[wr_ptr_q] == StIdle) && !bld_gnt_q;
    start_ok = bus.sa_start && (state_q[rd_ptr_q] == StRdy);
    ret_ok   = bus.sa_ret_ack && (state_q[rd_ptr_q] == StRead);
    hw_nxt   = hw_seen_q[fill_idx] | bus.hw_done;
    st_nxt   = st_seen_q[fill_idx] | bus.st_done;

    state_d    = state_q;
    seq_id_d   = seq_id_q;
    hw_seen_d  = hw_seen_q;
    st_seen_d  = st_seen_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    bld_gnt_d  = 1'b0;
    bld_bank_d = bld_bank_q;

    // Each event requires a distinct bank state, so they never collide.
    if (gnt_ok) begin
      bld_gnt_d           = 1'b1;
      bld_bank_d          = wr_ptr_q;
      seq_id_d[wr_ptr_q]  = bus.bld_seq_id;
      state_d[wr_ptr_q]   = StFill;
      hw_seen_d[wr_ptr_q] = 1'b0;
      st_seen_d[wr_ptr_q] = 1'b0;
      wr_ptr_d            = ~wr_ptr_q;
    end

    if (any_fill) begin
      hw_seen_d[fill_idx] = hw_nxt;
      st_seen_d[fill_idx] = st_nxt;
      if (hw_nxt && st_nxt) state_d[fill_idx] = StRdy;
    end

    if (start_ok) state_d[rd_ptr_q] = StRead;

    if (ret_ok) begin
      state_d[rd_ptr_q] = StIdle;
      rd_ptr_d          = ~rd_ptr_q;
    end

    lut_full_d[0] = (state_d[0] != StIdle);
    lut_full_d[1] = (state_d[1] != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]  <= StIdle;
      state_q[1]  <= StIdle;
      seq_id_q[0] <= '0;
      seq_id_q[1] <= '0;
      hw_seen_q   <= '0;
      st_seen_q   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      bld_gnt_q   <= 1'b0;
      bld_bank_q  <= 1'b0;
      lut_full_q  <= '0;
    end else begin
      state_q     <= state_d;
      seq_id_q    <= seq_id_d;
      hw_seen_q   <= hw_seen_d;
      st_seen_q   <= st_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bld_gnt_q   <= bld_gnt_d;
      bld_bank_q  <= bld_bank_d;
      lut_full_q  <= lut_full_d;
    end
  end

  assign bus.bld_gnt   = bld_gnt_q;
  assign bus.bld_bank  = bld_bank_q;
  assign bus.sa_vld    = (state_q[rd_ptr_q] == StRdy);
  assign bus.sa_bank   = rd_ptr_q;
  assign bus.sa_seq_id = seq_id_q[rd_ptr_q];
  assign bus.lut_full  = lut_full_q;

`ifdef CR_HUF_COMP_LUT_PP_SEQCHK_EN
  logic seq_err_q;

  // The bank is released regardless; a mismatch is only flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= ret_ok && (bus.sa_ack_seq_id != seq_id_q[rd_ptr_q]);
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  logic [SEQ_W-1:0] unused_ack_seq_id;
  assign unused_ack_seq_id = bus.sa_ack_seq_id;
  assign bus.seq_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cr_huf_comp_lut_pp_ctrl.sv
// Self-checking bench for cr_huf_comp_lut_pp_ctrl: a per-cycle vector table
// plus hand-written stall / done-ordering / reset sequences. An SA-side
// scoreboard checks bank and sequence id, in order, on every SA start.
module tb_cr_huf_comp_lut_pp_ctrl;
  localparam int unsigned SW = 8;
`ifdef CR_HUF_COMP_LUT_PP_SEQCHK_EN
  localparam bit SEQCHK = 1'b1;
`else
  localparam bit SEQCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_huf_comp_lut_pp_ctrl_if #(.SEQ_W(SW)) bus ();
  cr_huf_comp_lut_pp_ctrl #(.SEQ_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit rst; bit req; logic [7:0] seq; bit hw; bit st; bit start; bit ack; logic [7:0] aseq;
    bit e_gnt; bit e_bank; bit e_vld; bit e_sab; logic [7:0] e_saseq; logic [1:0] e_full;
    bit e_err;
  } vec_t;

  typedef struct { bit bank; logic [7:0] seq; } sb_t;

  vec_t tv [21];
  sb_t  sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_wr = 1'b0;

  function automatic vec_t mk(bit rst, bit req, logic [7:0] seq, bit hw, bit st, bit start,
                              bit ack, logic [7:0] aseq, bit e_gnt, bit e_bank, bit e_vld,
                              bit e_sab, logic [7:0] e_saseq, logic [1:0] e_full, bit e_err);
    vec_t v;
    v.rst = rst; v.req = req; v.seq = seq; v.hw = hw; v.st = st; v.start = start;
    v.ack = ack; v.aseq = aseq; v.e_gnt = e_gnt; v.e_bank = e_bank; v.e_vld = e_vld;
    v.e_sab = e_sab; v.e_saseq = e_saseq; v.e_full = e_full; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string p, input bit gnt, input bit bank, input bit vld,
                          input bit sab, input logic [7:0] saseq, input logic [1:0] full,
                          input bit err);
    chk({p, "_gnt"}, bus.bld_gnt, gnt);
    chk({p, "_bank"}, bus.bld_bank, bank);
    chk({p, "_vld"}, bus.sa_vld, vld);
    chk({p, "_sa_bank"}, bus.sa_bank, sab);
    chk({p, "_sa_seq"}, bus.sa_seq_id, saseq);
    chk({p, "_full"}, bus.lut_full, full);
    chk({p, "_err"}, bus.seq_err, err);
  endtask

  // Scoreboard consumer: every SA start must match the oldest expected build.
  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (rst_n && bus.sa_start && bus.sa_vld) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got sa_start on bank %0d expected no pending build",
                 bus.sa_bank);
      end else begin
        e = sb_q.pop_front();
        chk("sb_sa_bank", bus.sa_bank, e.bank);
        chk("sb_sa_seq", bus.sa_seq_id, e.seq);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.hw_done    = 1'b0;
    bus.st_done    = 1'b0;
    bus.sa_start   = 1'b0;
    bus.sa_ret_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.bld_req = 1'b0;
    sb_q.delete();
    exp_wr = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic build(input logic [7:0] s);
    sb_t t;
    bit  got;
    bus.bld_req    = 1'b1;
    bus.bld_seq_id = s;
    t.bank = exp_wr;
    t.seq  = s;
    sb_q.push_back(t);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      cyc();
      got = bus.bld_gnt;
    end
    chk("build_gnt_seen", got, 1);
    chk("build_gnt_bank", bus.bld_bank, exp_wr);
    exp_wr = ~exp_wr;
    bus.bld_req = 1'b0;
  endtask

  task automatic complete();
    bus.hw_done = 1'b1;
    bus.st_done = 1'b1;
    cyc();
  endtask

  task automatic finish_rd(input logic [7:0] aseq);
    bus.sa_start = 1'b1;
    cyc();
    bus.sa_ret_ack    = 1'b1;
    bus.sa_ack_seq_id = aseq;
    cyc();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    sb_t t;
    bus.bld_req = 1'b0; bus.bld_seq_id = '0; bus.hw_done = 1'b0; bus.st_done = 1'b0;
    bus.sa_start = 1'b0; bus.sa_ret_ack = 1'b0; bus.sa_ack_seq_id = '0;

    //       rst req seq hw st sta ack aseq  gnt bnk vld sab saseq full   err
    tv[0]  = mk(0, 1, 5, 0, 0, 0, 0, 0,     1, 0, 0, 0, 5, 2'b01, 0);
    tv[1]  = mk(0, 0, 0, 1, 1, 0, 0, 0,     0, 0, 1, 0, 5, 2'b01, 0);
    tv[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0,     0, 0, 0, 0, 5, 2'b01, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 1, 5,     0, 0, 0, 1, 0, 2'b00, 0);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 1, 0, 2'b00, 0);
    tv[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 2'b00, 0);
    tv[6]  = mk(0, 1, 1, 0, 0, 0, 0, 0,     1, 0, 0, 0, 1, 2'b01, 0);
    tv[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 2'b01, 0);
    tv[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 1, 0, 1, 2'b01, 0);
    tv[9]  = mk(0, 1, 2, 0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 2'b11, 0);
    tv[10] = mk(0, 0, 0, 1, 1, 0, 0, 0,     0, 1, 1, 0, 1, 2'b11, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 1, 0, 0,     0, 1, 0, 0, 1, 2'b11, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 1, 0, 0, 1, 2'b11, 0);
    tv[13] = mk(0, 0, 0, 0, 0, 0, 1, 1,     0, 1, 1, 1, 2, 2'b10, 0);
    tv[14] = mk(0, 0, 0, 0, 0, 1, 0, 0,     0, 1, 0, 1, 2, 2'b10, 0);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 1, 2,     0, 1, 0, 0, 1, 2'b00, 0);
    tv[16] = mk(0, 1, 6, 0, 0, 0, 0, 0,     1, 0, 0, 0, 6, 2'b01, 0);
    tv[17] = mk(0, 0, 0, 1, 1, 0, 0, 0,     0, 0, 1, 0, 6, 2'b01, 0);
    tv[18] = mk(0, 0, 0, 0, 0, 1, 0, 0,     0, 0, 0, 0, 6, 2'b01, 0);
    tv[19] = mk(0, 0, 0, 0, 0, 0, 1, 7,     0, 0, 0, 1, 2, 2'b00, SEQCHK);
    tv[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 1, 2, 2'b00, 0);

    // Reset values while rst_n is low.
    cyc();
    chk_outs("rst", 0, 0, 0, 0, 0, 2'b00, 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 21; i++) begin
      rst_n             = !tv[i].rst;
      bus.bld_req       = tv[i].req;
      bus.bld_seq_id    = tv[i].seq;
      bus.hw_done       = tv[i].hw;
      bus.st_done       = tv[i].st;
      bus.sa_start      = tv[i].start;
      bus.sa_ret_ack    = tv[i].ack;
      bus.sa_ack_seq_id = tv[i].aseq;
      if (tv[i].rst) sb_q.delete();
      if (tv[i].req) begin
        t.bank = tv[i].e_bank;
        t.seq  = tv[i].seq;
        sb_q.push_back(t);
      end
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), tv[i].e_gnt, tv[i].e_bank, tv[i].e_vld, tv[i].e_sab,
               tv[i].e_saseq, tv[i].e_full, tv[i].e_err);
    end
    bus.bld_req = 1'b0; bus.sa_ret_ack = 1'b0; bus.sa_start = 1'b0;
    bus.hw_done = 1'b0; bus.st_done = 1'b0;

    // Full stall: both banks busy, request waits for bank 0's release.
    do_reset();
    build(10);
    complete();
    build(11);
    complete();
    chk("stall_full", bus.lut_full, 2'b11);
    bus.bld_req    = 1'b1;
    bus.bld_seq_id = 3;
    t.bank = 1'b0;
    t.seq  = 3;
    sb_q.push_back(t);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_no_gnt", bus.bld_gnt, 0);
    end
    bus.sa_start = 1'b1;
    cyc();
    chk("stall_start_no_gnt", bus.bld_gnt, 0);
    bus.sa_ret_ack    = 1'b1;
    bus.sa_ack_seq_id = 10;
    cyc();
    chk("stall_ack_no_gnt", bus.bld_gnt, 0);
    chk("stall_ack_full", bus.lut_full, 2'b10);
    cyc();
    chk("stall_gnt", bus.bld_gnt, 1);
    chk("stall_gnt_bank", bus.bld_bank, 0);
    bus.bld_req = 1'b0;
    exp_wr = 1'b1;
    cyc();
    chk("stall_gnt_pulse", bus.bld_gnt, 0);

    // Done ordering: st_done four cycles ahead of hw_done, then stray dones.
    do_reset();
    build(4);
    bus.st_done = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("ord_wait_vld", bus.sa_vld, 0);
      cyc();
    end
    chk("ord_pre_hw_vld", bus.sa_vld, 0);
    bus.hw_done = 1'b1;
    cyc();
    chk("ord_vld", bus.sa_vld, 1);
    chk("ord_seq", bus.sa_seq_id, 4);
    bus.sa_start = 1'b1;
    cyc();
    bus.hw_done = 1'b1;
    bus.st_done = 1'b1;
    cyc();
    chk("stray_full", bus.lut_full, 2'b01);
    chk("stray_vld", bus.sa_vld, 0);
    bus.sa_ret_ack    = 1'b1;
    bus.sa_ack_seq_id = 4;
    cyc();
    chk("stray_rel_full", bus.lut_full, 2'b00);
    build(8);
    bus.hw_done = 1'b1;
    cyc();
    chk("stray_hw_only_vld", bus.sa_vld, 0);
    bus.st_done = 1'b1;
    cyc();
    chk("b1_vld", bus.sa_vld, 1);
    chk("b1_sa_bank", bus.sa_bank, 1);
    chk("b1_sa_seq", bus.sa_seq_id, 8);
    finish_rd(8);
    chk("b1_rel_full", bus.lut_full, 2'b00);

    // Reset mid-fill: bank 0 RDY, bank 1 FILL.
    do_reset();
    build(20);
    complete();
    build(21);
    rst_n = 1'b0;
    sb_q.delete();
    exp_wr = 1'b0;
    #1;
    chk_outs("rstmid", 0, 0, 0, 0, 0, 2'b00, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    build(22);
    complete();
    chk("rstmid_sa_bank", bus.sa_bank, 0);
    chk("rstmid_sa_seq", bus.sa_seq_id, 22);
    finish_rd(22);
    cyc();
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
